ddr2_rd_fifo_reader: RTL and testbench
======================================

Name: ddr2_rd_fifo_reader

Overview:
- Read-data FIFO engine for the DDR2 read path.
- Accepts read-data beats captured from the PHY into 16-entry dual-port distributed storage, then drains them to the user side through a registered valid/ready output stage.
- Owns write/read pointers, full/empty tracking, the output register and overflow detection.
- Sits between the read-capture logic and the user read interface.

Parameters:
- DATA_WIDTH, 32, width of one read-data beat (equals `MEMORY_WIDTH in normal builds).
- AF_THRESH, 12, occupancy at or above which almost_full asserts (1..15).

Ports:
- clk  input  1  single clock for both write and read sides
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  push one beat from capture logic
- wr_data  input  DATA_WIDTH  beat to push
- full  output  1  storage holds 16 entries
- almost_full  output  1  occupancy >= AF_THRESH
- dout  output  DATA_WIDTH  registered output beat
- dout_valid  output  1  dout holds a valid beat
- dout_ready  input  1  user accepts dout this cycle
- overflow  output  1  sticky: a push was attempted while full
- ovf_clr  input  1  clears overflow

Behaviour:
- Reset (rst_n low, asynchronous): pointers = 0, dout = 0, dout_valid = 0, full = 0, almost_full = 0, overflow = 0.
- Storage:
  - 16 x DATA_WIDTH, synchronous write, asynchronous read at rd_ptr.
  - Storage contents are not reset.
- Pointers:
  - wr_ptr and rd_ptr are 5 bits: 4-bit address plus wrap bit.
  - Increment modulo 32, so the address wraps 15 -> 0.
  - empty (internal) when pointers are equal.
  - full when the addresses are equal and the wrap bits differ.
  - Occupancy = wr_ptr - rd_ptr, computed 5-bit modulo 32, range 0..16.
- Push:
  - A push occurs on wr_en && !full.
  - It writes mem[wr_ptr[3:0]] and increments wr_ptr at the same edge.
- Drop on full:
  - wr_en && full drops the beat; storage and pointers are unchanged.
  - overflow sets at that edge and holds until an edge with ovf_clr high.
  - If set and clear occur on the same edge, set wins.
- Output stage (one register):
  - Load condition: (!dout_valid || dout_ready) && !empty.
  - On load: dout <= mem[rd_ptr[3:0]], dout_valid <= 1, rd_ptr increments.
  - If dout_valid && dout_ready && empty: dout_valid <= 0 and dout holds its last value.
  - dout and dout_valid change only at clk edges.
- Latency: a beat pushed at edge E into an empty FIFO with dout_valid = 0 appears with dout_valid = 1 after edge E+1.
- Throughput: one beat per cycle in steady state with dout_ready held high.
- full and almost_full:
  - Registered: recomputed from the next-state pointers, so they are valid in the cycle following the causing edge.
  - A pop frees a slot in the same cycle as a simultaneous push at full? No: while full = 1, wr_en is dropped even if a pop occurs that edge. The freed slot is usable from the next cycle.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.
- Reset mid-stream discards all stored and in-flight beats.
- dout_ready while dout_valid = 0 has no effect.

Optional Feature:
- Macro: DDR2_RD_FIFO_LEVEL_EN.
- When defined:
  - Adds output port fifo_level (5 bits), a registered copy of storage occupancy 0..16, reset 0.
  - The beat held in dout is excluded from fifo_level.
- When undefined:
  - The port is absent and no level register is built.
  - All other behaviour is identical.

Test Plan:
- Reset/basic: reset, then push 0xA5A5_0001 with dout_ready = 0 -> dout_valid = 1 after the second edge, dout = 0xA5A5_0001, full = 0, overflow = 0.
- Fill and overflow:
  - dout_ready = 0, push 17 beats (values 1..17).
  - Required response: the output register takes beat 1; beats 2..17 fill storage.
  - full asserts after the 17th push (16 in storage); almost_full asserts once 12 are stored.
  - A further push of 18 -> dropped, overflow = 1.
  - ovf_clr -> overflow = 0.
- Drain order and wrap: after the fill, hold dout_ready = 1 -> dout sequence 1..17 on consecutive cycles, then dout_valid = 0. Repeat 3 times so the pointers wrap past 15 -> same ordering, no loss.
- Simultaneous push/pop:
  - Level 5, wr_en = 1 and dout_ready = 1 for 20 cycles.
  - Required response: occupancy stays 5, beats emerge in push order with a 1-beat/cycle cadence.
  - With DDR2_RD_FIFO_LEVEL_EN, fifo_level = 5 throughout.
- Backpressure: alternate dout_ready 1/0 while pushing every cycle -> no beat duplicated or skipped, dout stable while dout_valid = 1 and dout_ready = 0.
- Async reset mid-operation: assert rst_n low between edges at level 9 with dout_valid = 1 -> dout_valid, full and overflow drop to 0 immediately. After release, the first new push appears 2 edges later, with no stale beats.

Source files
------------

// File: rtl/ddr2_rd_fifo_reader.sv
// 16-entry DDR2 read-data FIFO with a registered valid/ready output stage and sticky overflow.
// Define DDR2_RD_FIFO_LEVEL_EN to add the registered fifo_level occupancy output.
module ddr2_rd_fifo_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overflow,
  input  logic                  ovf_clr
`ifdef DDR2_RD_FIFO_LEVEL_EN
  ,
  output logic [4:0]            fifo_level
`endif
);

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      occ_d;
  logic                  full_q, full_d;
  logic                  af_q, af_d;
  logic                  dv_q, dv_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  empty_c, push_c, load_c;

  // Next-state pointers, flags and output stage; full/almost_full come from the next pointers.
  always_comb begin
    empty_c  = (wr_ptr_q == rd_ptr_q);
    push_c   = wr_en && !full_q;
    load_c   = (!dv_q || dout_ready) && !empty_c;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(load_c);
    occ_d    = wr_ptr_d - rd_ptr_d;
    full_d   = (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
               (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
    af_d     = (occ_d >= AF_LVL);
    dout_d   = dout_q;
    dv_d     = dv_q;
    ovf_d    = ovf_q;
    if (load_c) begin
      dout_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
      dv_d   = 1'b1;
    end else if (dv_q && dout_ready) begin
      dv_d   = 1'b0;
    end
    // A drop on the same edge as a clear keeps the flag set.
    if (wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      af_q     <= af_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
    end
  end

`ifdef DDR2_RD_FIFO_LEVEL_EN
  logic [PTR_W-1:0] level_q;

  // Storage occupancy only; the beat held in dout is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= occ_d;
    end
  end

  assign fifo_level = level_q;
`endif

  assign full        = full_q;
  assign almost_full = af_q;
  assign dout        = dout_q;
  assign dout_valid  = dv_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ddr2_rd_fifo_reader.sv
// Self-checking bench for ddr2_rd_fifo_reader: directed scenarios plus a randomized run
// against a queue-based reference model of the FIFO and its output register.
module tb_ddr2_rd_fifo_reader;

  localparam int AF = 12;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic        almost_full;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        overflow;
  logic        ovf_clr;
`ifdef DDR2_RD_FIFO_LEVEL_EN
  logic [4:0]  fifo_level;
`endif

  int ntests = 0;
  int nfail  = 0;

  // Reference model: stored beats, output register and sticky overflow.
  logic [31:0] sq[$];
  logic [31:0] acc_q[$];
  bit          mv;
  logic [31:0] md;
  bit          movf;

  ddr2_rd_fifo_reader #(.DATA_WIDTH(32), .AF_THRESH(AF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .almost_full(almost_full),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
`ifdef DDR2_RD_FIFO_LEVEL_EN
    ,
    .fifo_level (fifo_level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, advance one edge, update the model, settle to edge+1.
  task automatic tick(input logic wr, input logic [31:0] d, input logic rdy, input logic clr);
    bit was_full;
    bit ld;
    wr_en = wr; wr_data = d; dout_ready = rdy; ovf_clr = clr;
    if (dout_valid && rdy) acc_q.push_back(dout);
    @(posedge clk);
    was_full = (sq.size() == 16);
    ld = (!mv || rdy) && (sq.size() != 0);
    if (wr && was_full) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (ld) begin
      md = sq.pop_front();
      mv = 1'b1;
    end else if (rdy) begin
      mv = 1'b0;
    end
    if (wr && !was_full) sq.push_back(d);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_en = 0; wr_data = 0; dout_ready = 0; ovf_clr = 0;
    sq.delete(); mv = 0; md = 0; movf = 0;
    repeat (3) @(posedge clk);
    #1;
    ntests++;
    if ({dout_valid, full, almost_full, overflow} !== 4'b0000 || dout !== 32'h0) begin
      nfail++;
      $display("FAIL reset_hold: v/f/af/o=%b dout=%h, want 0000 dout=0",
               {dout_valid, full, almost_full, overflow}, dout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 0, 0);
    ntests++;
    if ({dout_valid, full, almost_full, overflow} !== 4'b0000) begin
      nfail++;
      $display("FAIL reset_release: v/f/af/o=%b, want 0000", {dout_valid, full, almost_full, overflow});
    end
`ifdef DDR2_RD_FIFO_LEVEL_EN
    ntests++;
    if (fifo_level !== 5'd0) begin
      nfail++;
      $display("FAIL reset_level: got %0d want 0", fifo_level);
    end
`endif
  endtask

  task automatic test_basic;
    tick(1, 32'hA5A5_0001, 0, 0);
    ntests++;
    if (dout_valid !== 1'b0) begin
      nfail++;
      $display("FAIL basic_edge1: dout_valid=%b want 0", dout_valid);
    end
    tick(0, 0, 0, 0);
    ntests++;
    if (dout_valid !== 1'b1 || dout !== 32'hA5A5_0001 || full !== 1'b0 || overflow !== 1'b0) begin
      nfail++;
      $display("FAIL basic_edge2: v=%b dout=%h f=%b o=%b, want v=1 dout=a5a50001 f=0 o=0",
               dout_valid, dout, full, overflow);
    end
    tick(0, 0, 1, 0);
    ntests++;
    if (dout_valid !== 1'b0 || dout !== 32'hA5A5_0001) begin
      nfail++;
      $display("FAIL basic_drain: v=%b dout=%h, want v=0 dout=a5a50001 held", dout_valid, dout);
    end
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 17; i++) begin
      tick(1, 32'(i), 0, 0);
      ntests++;
      if (full !== (i == 17) || almost_full !== (i >= 13) || dout_valid !== (i >= 2)) begin
        nfail++;
        $display("FAIL fill_push%0d: f=%b af=%b v=%b, want f=%b af=%b v=%b",
                 i, full, almost_full, dout_valid, (i == 17), (i >= 13), (i >= 2));
      end
    end
    ntests++;
    if (dout !== 32'd1) begin
      nfail++;
      $display("FAIL fill_head: dout=%0d want 1", dout);
    end
    tick(1, 32'd18, 0, 0);
    ntests++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      nfail++;
      $display("FAIL overflow_set: o=%b f=%b, want o=1 f=1", overflow, full);
    end
    tick(0, 0, 0, 1);
    ntests++;
    if (overflow !== 1'b0 || full !== 1'b1 || dout !== 32'd1) begin
      nfail++;
      $display("FAIL overflow_clr: o=%b f=%b dout=%0d, want o=0 f=1 dout=1", overflow, full, dout);
    end
  endtask

  task automatic test_drain_wrap;
    for (int r = 0; r < 3; r++) begin
      if (r > 0) begin
        for (int i = 1; i <= 17; i++) tick(1, 32'(r * 100 + i), 0, 0);
        ntests++;
        if (full !== 1'b1) begin
          nfail++;
          $display("FAIL wrap_full_r%0d: f=%b want 1", r, full);
        end
      end
      for (int k = 1; k <= 17; k++) begin
        ntests++;
        if (dout_valid !== 1'b1 || dout !== 32'(r * 100 + k)) begin
          nfail++;
          $display("FAIL drain_r%0d_k%0d: v=%b dout=%0d, want v=1 dout=%0d",
                   r, k, dout_valid, dout, r * 100 + k);
        end
        tick(0, 0, 1, 0);
      end
      ntests++;
      if (dout_valid !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0) begin
        nfail++;
        $display("FAIL drain_end_r%0d: v=%b f=%b af=%b, want 000", r, dout_valid, full, almost_full);
      end
    end
  endtask

  task automatic test_simultaneous;
    for (int i = 1; i <= 6; i++) tick(1, 32'(200 + i), 0, 0);
    for (int c = 0; c < 20; c++) begin
      tick(1, 32'(207 + c), 1, 0);
      ntests++;
      if (dout_valid !== 1'b1 || dout !== 32'(202 + c) || full !== 1'b0 || almost_full !== 1'b0) begin
        nfail++;
        $display("FAIL simul_c%0d: v=%b dout=%0d f=%b af=%b, want v=1 dout=%0d f=0 af=0",
                 c, dout_valid, dout, full, almost_full, 202 + c);
      end
`ifdef DDR2_RD_FIFO_LEVEL_EN
      ntests++;
      if (fifo_level !== 5'd5) begin
        nfail++;
        $display("FAIL simul_level_c%0d: got %0d want 5", c, fifo_level);
      end
`endif
    end
    for (int k = 222; k <= 226; k++) begin
      tick(0, 0, 1, 0);
      ntests++;
      if (dout_valid !== 1'b1 || dout !== 32'(k)) begin
        nfail++;
        $display("FAIL simul_tail: v=%b dout=%0d, want v=1 dout=%0d", dout_valid, dout, k);
      end
    end
    tick(0, 0, 1, 0);
    ntests++;
    if (dout_valid !== 1'b0) begin
      nfail++;
      $display("FAIL simul_empty: v=%b want 0", dout_valid);
    end
  endtask

  task automatic test_backpressure;
    logic        rdy;
    logic        held;
    logic [31:0] prev_d;
    acc_q.delete();
    for (int c = 0; c < 24; c++) begin
      rdy    = (c % 2 == 0);
      held   = dout_valid && !rdy;
      prev_d = dout;
      tick(1, 32'(300 + c), rdy, 0);
      if (held) begin
        ntests++;
        if (dout_valid !== 1'b1 || dout !== prev_d) begin
          nfail++;
          $display("FAIL bp_stable_c%0d: v=%b dout=%0d, want v=1 dout=%0d", c, dout_valid, dout, prev_d);
        end
      end
    end
    repeat (20) tick(0, 0, 1, 0);
    ntests++;
    if (acc_q.size() != 24) begin
      nfail++;
      $display("FAIL bp_count: accepted %0d beats, want 24", acc_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        ntests++;
        if (acc_q[i] !== 32'(300 + i)) begin
          nfail++;
          $display("FAIL bp_order_%0d: got %0d want %0d", i, acc_q[i], 300 + i);
        end
      end
    end
  endtask

  task automatic test_random;
    logic wr, rdy, clr;
    for (int c = 0; c < 400; c++) begin
      wr  = ($urandom_range(0, 3) != 0);
      rdy = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 15) == 0);
      tick(wr, $urandom, rdy, clr);
      ntests++;
      if (dout_valid !== mv || full !== (sq.size() == 16) || almost_full !== (sq.size() >= AF) ||
          overflow !== movf || (mv && dout !== md)) begin
        nfail++;
        $display("FAIL rand_c%0d: v=%b d=%h f=%b af=%b o=%b, want v=%b d=%h f=%b af=%b o=%b",
                 c, dout_valid, dout, full, almost_full, overflow,
                 mv, md, (sq.size() == 16), (sq.size() >= AF), movf);
      end
`ifdef DDR2_RD_FIFO_LEVEL_EN
      ntests++;
      if (fifo_level !== 5'(sq.size())) begin
        nfail++;
        $display("FAIL rand_level_c%0d: got %0d want %0d", c, fifo_level, sq.size());
      end
`endif
    end
    repeat (20) tick(0, 0, 1, 1);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 18; i++) tick(1, 32'(400 + i), 0, 0);
    repeat (20) tick(0, 0, 1, 0);
    for (int i = 1; i <= 10; i++) tick(1, 32'(500 + i), 0, 0);
    ntests++;
    if (dout_valid !== 1'b1 || overflow !== 1'b1 || dout !== 32'd501) begin
      nfail++;
      $display("FAIL areset_pre: v=%b o=%b dout=%0d, want v=1 o=1 dout=501", dout_valid, overflow, dout);
    end
    #2;
    rst_n = 1'b0; wr_en = 0; dout_ready = 0; ovf_clr = 0;
    #1;
    ntests++;
    if ({dout_valid, full, almost_full, overflow} !== 4'b0000) begin
      nfail++;
      $display("FAIL areset_now: v/f/af/o=%b, want 0000", {dout_valid, full, almost_full, overflow});
    end
    sq.delete(); mv = 0; movf = 0;
    #3;
    rst_n = 1'b1;
    tick(1, 32'hBEEF_0001, 1, 0);
    ntests++;
    if (dout_valid !== 1'b0) begin
      nfail++;
      $display("FAIL areset_edge1: v=%b want 0", dout_valid);
    end
    tick(0, 0, 1, 0);
    ntests++;
    if (dout_valid !== 1'b1 || dout !== 32'hBEEF_0001) begin
      nfail++;
      $display("FAIL areset_edge2: v=%b dout=%h, want v=1 dout=beef0001", dout_valid, dout);
    end
    tick(0, 0, 1, 0);
    ntests++;
    if (dout_valid !== 1'b0) begin
      nfail++;
      $display("FAIL areset_stale: v=%b dout=%h, want v=0", dout_valid, dout);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_overflow();
    test_drain_wrap();
    test_simultaneous();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
